adder_result_checker: RTL and testbench

- Downstream stage of the adder self-test datapath: consumes one {index, adder result, golden value} record per vector over a valid/ready handshake.
- Compares each result against its golden value and keeps pass/fail statistics, the first failing index, and round and sequence tracking.
- Drives a status LED: steady on while all results pass; a repeating blink code showing the failure count once any result fails.

---
 rtl/adder_result_checker.sv | 164 ++++++++++++++++
 tb/tb_adder_result_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// adder_result_checker: checks adder results against golden values, keeps pass/fail,
// round and sequence statistics, and drives a blink-coded status LED.
module adder_result_checker #(
    parameter int N        = 10,
    parameter int W        = 32,
    parameter int TICK_DIV = 25_000_000,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [W-1:0]     in_sum,
    input  logic             in_cout,
    input  logic [W:0]       in_exp,
    input  logic             clear,
    output logic             pass,
    output logic             done,
    output logic [7:0]       fail_cnt,
    output logic [15:0]      round_cnt,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             first_fail_valid,
    output logic             seq_err,
    output logic             led
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TICK_DIV - 1);

    typedef enum logic {C_IDLE, C_CMP} cst_t;
    typedef enum logic [1:0] {L_PASS, L_ON, L_OFF, L_GAP} lst_t;

    cst_t             cst_q, cst_d;
    lst_t             lst_q, lst_d;
    logic [IDX_W-1:0] idx_q, idx_d, exp_idx_q, exp_idx_d, ffi_q, ffi_d;
    logic [W:0]       res_q, res_d, gold_q, gold_d;
    logic             pass_q, pass_d, done_q, done_d, ffv_q, ffv_d, seq_q, seq_d;
    logic [7:0]       fail_q, fail_d;
    logic [15:0]      round_q, round_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [3:0]       blinks_q, blinks_d, snap;
    logic [1:0]       gap_q, gap_d;
    logic             tick_hit, miss;

    always_comb begin
        in_ready  = rst_n && !clear && cst_q == C_IDLE;
        tick_hit  = tick_q == LAST_TICK;
        snap      = fail_q > 8'd15 ? 4'd15 : fail_q[3:0];
        miss      = res_q != gold_q;
        cst_d     = cst_q;
        lst_d     = lst_q;
        idx_d     = idx_q;
        res_d     = res_q;
        gold_d    = gold_q;
        exp_idx_d = exp_idx_q;
        ffi_d     = ffi_q;
        pass_d    = pass_q;
        done_d    = done_q;
        ffv_d     = ffv_q;
        seq_d     = seq_q;
        fail_d    = fail_q;
        round_d   = round_q;
        blinks_d  = blinks_q;
        gap_d     = gap_q;
        if (cst_q == C_IDLE && in_valid && in_ready) begin
            cst_d  = C_CMP;
            idx_d  = in_idx;
            res_d  = {in_cout, in_sum};
            gold_d = in_exp;
        end else if (cst_q == C_CMP) begin
            cst_d     = C_IDLE;
            pass_d    = pass_q && !miss;
            fail_d    = miss && fail_q != 8'hFF ? fail_q + 8'd1 : fail_q;
            ffi_d     = miss && !ffv_q ? idx_q : ffi_q;
            ffv_d     = ffv_q || miss;
            seq_d     = seq_q || idx_q != exp_idx_q || idx_q > LAST_IDX;
            exp_idx_d = idx_q >= LAST_IDX ? '0 : idx_q + IDX_W'(1);
            done_d    = done_q || idx_q == LAST_IDX;
            round_d   = idx_q == LAST_IDX ? round_q + 16'd1 : round_q;
        end
        // The tick counter idles at zero in L_PASS so the first pulse is a full period.
        tick_d = lst_q == L_PASS || tick_hit ? '0 : tick_q + TW'(1);
        case (lst_q)
            L_PASS: if (!pass_q) begin
                lst_d    = L_ON;
                blinks_d = snap;
            end
            L_ON: if (tick_hit) lst_d = L_OFF;
            L_OFF: if (tick_hit) begin
                lst_d    = blinks_q > 4'd1 ? L_ON : L_GAP;
                blinks_d = blinks_q > 4'd1 ? blinks_q - 4'd1 : blinks_q;
                gap_d    = '0;
            end
            default: if (tick_hit) begin
                gap_d = gap_q + 2'd1;
                if (gap_q == 2'd3) begin
                    lst_d    = L_ON;
                    blinks_d = snap;
                end
            end
        endcase
        if (clear) begin
            cst_d     = C_IDLE;
            lst_d     = L_PASS;
            tick_d    = '0;
            exp_idx_d = '0;
            ffi_d     = '0;
            pass_d    = 1'b1;
            done_d    = 1'b0;
            ffv_d     = 1'b0;
            seq_d     = 1'b0;
            fail_d    = '0;
            round_d   = '0;
        end
        led = lst_q == L_ON || (lst_q == L_PASS && done_q && pass_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cst_q     <= C_IDLE;
            lst_q     <= L_PASS;
            idx_q     <= '0;
            res_q     <= '0;
            gold_q    <= '0;
            exp_idx_q <= '0;
            ffi_q     <= '0;
            pass_q    <= 1'b1;
            done_q    <= 1'b0;
            ffv_q     <= 1'b0;
            seq_q     <= 1'b0;
            fail_q    <= '0;
            round_q   <= '0;
            tick_q    <= '0;
            blinks_q  <= '0;
            gap_q     <= '0;
        end else begin
            cst_q     <= cst_d;
            lst_q     <= lst_d;
            idx_q     <= idx_d;
            res_q     <= res_d;
            gold_q    <= gold_d;
            exp_idx_q <= exp_idx_d;
            ffi_q     <= ffi_d;
            pass_q    <= pass_d;
            done_q    <= done_d;
            ffv_q     <= ffv_d;
            seq_q     <= seq_d;
            fail_q    <= fail_d;
            round_q   <= round_d;
            tick_q    <= tick_d;
            blinks_q  <= blinks_d;
            gap_q     <= gap_d;
        end
    end

    assign pass             = pass_q;
    assign done             = done_q;
    assign fail_cnt         = fail_q;
    assign round_cnt        = round_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;
    assign seq_err          = seq_q;
endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker: directed and random records checked every cycle against
// a queue-based behavioural model of the checker statistics and LED blink code.
module tb_adder_result_checker;
    localparam int N  = 10;
    localparam int TD = 4;

    logic        clk = 0, rst_n = 0, in_valid = 0, in_cout = 0, clear = 0;
    logic [3:0]  in_idx = 0;
    logic [31:0] in_sum = 0;
    logic [32:0] in_exp = 0;
    logic        in_ready, pass, done, first_fail_valid, seq_err, led;
    logic [7:0]  fail_cnt;
    logic [15:0] round_cnt;
    logic [3:0]  first_fail_idx;

    int n_chk = 0, n_fail = 0, cyc = 0;

    bit          started = 0, m_pass = 1, m_done = 0, m_ffv = 0, m_seq = 0, m_busy = 0, m_blink = 0, m_led = 0;
    int          m_fail = 0, m_round = 0, m_ffi = 0, m_exp_idx = 0, p_idx = 0;
    logic [32:0] p_res = 0, p_gold = 0;
    bit          led_q[$];

    adder_result_checker #(.N(N), .W(32), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_sum(in_sum), .in_cout(in_cout), .in_exp(in_exp),
        .clear(clear), .pass(pass), .done(done), .fail_cnt(fail_cnt),
        .round_cnt(round_cnt), .first_fail_idx(first_fail_idx),
        .first_fail_valid(first_fail_valid), .seq_err(seq_err), .led(led)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Behavioural model: one pending record, statistics, and a queue of future LED levels.
    always @(posedge clk) begin
        bit old_pass;
        int old_fail, b;
        cyc++;
        started = 1;
        if (!rst_n || clear) begin
            m_pass = 1; m_done = 0; m_ffv = 0; m_seq = 0; m_busy = 0; m_blink = 0; m_led = 0;
            m_fail = 0; m_round = 0; m_ffi = 0; m_exp_idx = 0;
            led_q.delete();
        end else begin
            old_pass = m_pass;
            old_fail = m_fail;
            if (m_busy) begin
                m_busy = 0;
                if (p_res != p_gold) begin
                    m_pass = 0;
                    if (m_fail < 255) m_fail++;
                    if (!m_ffv) begin m_ffi = p_idx; m_ffv = 1; end
                end
                if (p_idx != m_exp_idx || p_idx >= N) m_seq = 1;
                m_exp_idx = p_idx >= N - 1 ? 0 : p_idx + 1;
                if (p_idx == N - 1) begin m_done = 1; m_round = (m_round + 1) % 65536; end
            end else if (in_valid) begin
                m_busy = 1; p_idx = in_idx; p_res = {in_cout, in_sum}; p_gold = in_exp;
            end
            if (!old_pass) m_blink = 1;
            if (m_blink) begin
                if (led_q.size() == 0) begin
                    b = old_fail > 15 ? 15 : old_fail;
                    repeat (b) begin
                        repeat (TD) led_q.push_back(1);
                        repeat (TD) led_q.push_back(0);
                    end
                    repeat (4 * TD) led_q.push_back(0);
                end
                m_led = led_q.pop_front();
            end else m_led = m_done && m_pass;
        end
    end

    always @(negedge clk) if (started) begin
        chk("in_ready", in_ready, rst_n && !clear && !m_busy);
        chk("pass", pass, m_pass);
        chk("done", done, m_done);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("round_cnt", round_cnt, m_round);
        chk("first_fail_idx", first_fail_idx, m_ffi);
        chk("first_fail_valid", first_fail_valid, m_ffv);
        chk("seq_err", seq_err, m_seq);
        chk("led", led, m_led);
    end

    task automatic send(input int idx, input logic [31:0] s, input logic c, input logic [32:0] e);
        in_valid = 1; in_idx = idx[3:0]; in_sum = s; in_cout = c; in_exp = e;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (in_ready) begin
                @(negedge clk); #1;
                return;
            end
            @(negedge clk); #1;
        end
        n_chk++; n_fail++;
        $display("FAIL send_timeout: record idx %0d not accepted within 8 cycles", idx);
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        in_valid = 0; clear = 1;
        @(negedge clk); #1;
        clear = 0;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (led) hi++;
        end
        #1;
    endtask

    initial begin
        int t0, hi;
        logic [31:0] s;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pass", pass, 1);
        chk("rst_led", led, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_ffv", first_fail_valid, 0);
        #1 rst_n = 1;
        t0 = cyc;
        for (int i = 0; i < N; i++) begin
            s = $urandom;
            if (i == 4) send(i, 32'h0, 1'b1, 33'h1_0000_0000);
            else send(i, s, 1'b0, {1'b0, s});
        end
        chk("stream_cycles", cyc - t0, 19);
        idle(2);
        chk("r1_pass", pass, 1);
        chk("r1_fail_cnt", fail_cnt, 0);
        chk("r1_done", done, 1);
        chk("r1_round_cnt", round_cnt, 1);
        chk("r1_led", led, 1);
        chk("r1_seq_err", seq_err, 0);
        for (int i = 0; i < N; i++) begin
            s = $urandom;
            if (i == 3) send(3, 32'hFFFF_FFFE, 1'b0, 33'h0_FFFF_FFFF);
            else if (i == 5) send(5, 32'h5, 1'b0, 33'h6);
            else send(i, s, 1'b0, {1'b0, s});
        end
        idle(2);
        chk("r2_pass", pass, 0);
        chk("r2_fail_cnt", fail_cnt, 2);
        chk("r2_first_fail_idx", first_fail_idx, 3);
        chk("r2_ffv", first_fail_valid, 1);
        chk("r2_round_cnt", round_cnt, 2);
        idle(40);
        count_high(64, hi);
        chk("blink2_high_cycles", hi, 16);
        pulse_clear();
        send(0, 32'h10, 1'b0, 33'h10);
        send(1, 32'h11, 1'b0, 33'h11);
        send(4, 32'h14, 1'b0, 33'h14);
        idle(2);
        chk("seq_err_set", seq_err, 1);
        chk("seq_pass", pass, 1);
        for (int i = 5; i < N; i++) send(i, 32'h20, 1'b0, 33'h20);
        idle(2);
        chk("seq_round_cnt", round_cnt, 1);
        chk("seq_done", done, 1);
        send(0, 32'h1, 1'b0, 33'h2);
        clear = 1; in_valid = 0;
        @(negedge clk);
        chk("clr_pass", pass, 1);
        chk("clr_fail_cnt", fail_cnt, 0);
        chk("clr_ffv", first_fail_valid, 0);
        chk("clr_led", led, 0);
        #1 clear = 0;
        send(0, 32'h1, 1'b0, 33'h2);
        rst_n = 0; in_valid = 0;
        @(negedge clk);
        chk("rstmid_pass", pass, 1);
        chk("rstmid_fail_cnt", fail_cnt, 0);
        chk("rstmid_in_ready", in_ready, 0);
        #1 rst_n = 1;
        pulse_clear();
        for (int i = 0; i < 300; i++) begin
            s = $urandom;
            send(i % N, s, 1'b0, {1'b1, s});
        end
        idle(2);
        chk("sat_fail_cnt", fail_cnt, 255);
        chk("sat_round_cnt", round_cnt, 30);
        chk("sat_first_fail_idx", first_fail_idx, 0);
        count_high(136, hi);
        chk("blink15_high_cycles", hi, 60);
        for (int i = 0; i < 3000; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_idx   = $urandom_range(0, 9) == 0 ? 4'($urandom_range(0, 15)) : 4'(m_exp_idx);
            in_sum   = $urandom;
            in_cout  = 1'($urandom_range(0, 1));
            in_exp   = $urandom_range(0, 3) != 0 ? {in_cout, in_sum} : {1'($urandom), 32'($urandom)};
            clear    = $urandom_range(0, 60) == 0;
            rst_n    = $urandom_range(0, 200) != 0;
            @(negedge clk); #1;
        end
        clear = 0; rst_n = 1;
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
